// File: rtl/bcd_seq_pkg.sv
// Shared types and digit helpers for the digit-serial BCD add/sub sequencer.
package bcd_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} seq_state_e;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return BCD_NINE - d;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder: digit = (x+y+cin) mod 10, cout on decimal overflow.
module bcd_digit_add
  import bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);
  logic [DIGIT_W:0] s, s_adj;

  always_comb begin
    s     = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    s_adj = s - (DIGIT_W+1)'(10);
    cout  = (s > (DIGIT_W+1)'(9));
    digit = cout ? s_adj[DIGIT_W-1:0] : s[DIGIT_W-1:0];
  end
endmodule

// File: rtl/bcd_digit_sequencer.sv
// N-digit BCD add/subtract engine, one digit per cycle LSD first through a shared adder.
// Define BCD_SEQ_CHECK_EN to flag operand digits above nine on bcd_err.
module bcd_digit_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] result,
  output logic                      carry_out,
  output logic                      negative,
  output logic                      bcd_err
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIGITS-1:0][DIGIT_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic sub_q, sub_d, carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic cout_q, cout_d, neg_q, neg_d;
  logic [DIGIT_W-1:0] a_dig, b_dig, add_x, add_y, add_sum;
  logic add_cout;

  assign a_dig = a_q[idx_q];
  assign b_dig = b_q[idx_q];

  // FIX reuses the adder to turn the stored nines-complement into a magnitude.
  always_comb begin
    add_x = a_dig;
    add_y = sub_q ? nines_comp(b_dig) : b_dig;
    if (state_q == FIX) begin
      add_x = nines_comp(res_q[idx_q]);
      add_y = '0;
    end
  end

  bcd_digit_add u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (carry_q),
    .digit(add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        sub_d   = op_sub;
        res_d   = '0;
        cout_d  = 1'b0;
        neg_d   = 1'b0;
        idx_d   = '0;
        carry_d = op_sub;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        res_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          if (sub_q && !add_cout) begin
            neg_d   = 1'b1;
            idx_d   = '0;
            carry_d = 1'b1;
            state_d = FIX;
          end else begin
            cout_d  = sub_q ? 1'b0 : add_cout;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      FIX: begin
        res_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
    end
  end

`ifdef BCD_SEQ_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start)
      err_d = 1'b0;
    else if (state_q == RUN && (a_dig > BCD_NINE || b_dig > BCD_NINE))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bcd_err = err_q;
`else
  assign bcd_err = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign carry_out = cout_q;
  assign negative  = neg_q;
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed bench for bcd_digit_sequencer (DIGITS=4); latencies are edges after the accepting edge.
module tb_bcd_digit_sequencer;
  logic        clk, rst_n, start, op_sub;
  logic [15:0] a, b, result;
  logic        busy, done, carry_out, negative, bcd_err;
  int          vec, miss;

  bcd_digit_sequencer #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .negative(negative), .bcd_err(bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sub);
    @(negedge clk);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
  endtask

  // glitch >= 1: pulse start with foreign operands after that many edges; hold keeps start as-is
  task automatic wait_done(output int n, input int glitch, input bit hold);
    n = 0;
    while (!done && n < 40) begin
      if (!hold) begin
        if (n == glitch) begin
          start = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b1;
        end else start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sub,
                        input logic [15:0] er, input logic eco, input logic eneg,
                        input int elat, input int glitch, input string tag);
    int n;
    launch(av, bv, sub);
    chk(32'(busy), 32'(1), {tag, "/busy"});
    chk(32'(bcd_err), 32'(0), {tag, "/err_clr"});
    wait_done(n, glitch, 1'b0);
    chk(32'(n), 32'(elat), {tag, "/lat"});
    chk(32'(result), 32'(er), {tag, "/result"});
    chk(32'(carry_out), 32'(eco), {tag, "/carry"});
    chk(32'(negative), 32'(eneg), {tag, "/neg"});
    chk(32'(bcd_err), 32'(0), {tag, "/err"});
    @(posedge clk); #1;
    chk(32'({busy, done}), 32'(0), {tag, "/idle"});
  endtask

  initial begin
    int n;
    vec = 0; miss = 0;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(32'({busy, done, carry_out, negative, bcd_err}), 32'(0), "rst/flags");
    chk(32'(result), 32'(0), "rst/result");
    @(negedge clk); rst_n = 1'b1;

    run_op(16'h0042, 16'h0057, 1'b0, 16'h0099, 1'b0, 1'b0, 4, -1, "add42_57");
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4, -1, "add9999_1");
    run_op(16'h0057, 16'h0042, 1'b1, 16'h0015, 1'b0, 1'b0, 4, -1, "sub57_42");
    run_op(16'h0042, 16'h0057, 1'b1, 16'h0015, 1'b0, 1'b1, 8, -1, "sub42_57");
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 4, -1, "sub_eq");
    run_op(16'h0042, 16'h0057, 1'b0, 16'h0099, 1'b0, 1'b0, 4, 2, "start_busy");
    run_op(16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 8, -1, "sub0_1");

    // start held high through DONE is taken again in the following IDLE cycle
    launch(16'h0005, 16'h0003, 1'b0);
    wait_done(n, -1, 1'b1);
    chk(32'(result), 32'h0008, "hold/result1");
    @(posedge clk); #1;
    chk(32'(busy), 32'(0), "hold/idle");
    @(posedge clk); #1;
    chk(32'(busy), 32'(1), "hold/reaccept");
    a = 16'h0007; start = 1'b0;
    wait_done(n, -1, 1'b0);
    chk(32'(n), 32'(4), "hold/lat2");
    chk(32'(result), 32'h0008, "hold/result2");
    @(posedge clk); #1;

    // asynchronous reset in the middle of the FIX pass
    launch(16'h0042, 16'h0057, 1'b1);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(32'({busy, done, carry_out, negative, bcd_err}), 32'(0), "rstfix/flags");
    chk(32'(result), 32'(0), "rstfix/result");
    @(negedge clk); rst_n = 1'b1;
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 4, -1, "post_rst");

    // non-BCD operand digit
    launch(16'h00A1, 16'h0000, 1'b0);
    start = 1'b0;
    wait_done(n, -1, 1'b0);
    chk(32'(n), 32'(4), "bad/lat");
`ifdef BCD_SEQ_CHECK_EN
    chk(32'(bcd_err), 32'(1), "bad/err");
`else
    chk(32'(bcd_err), 32'(0), "bad/err_off");
`endif
    @(posedge clk); #1;
    run_op(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 4, -1, "after_bad");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bcd_digit_sequencer.md
# bcd_digit_sequencer

Digit-serial multi-digit BCD add/subtract controller. Latches two DIGITS-wide packed-BCD operands and feeds one digit per cycle, LSD first, through a single shared one-digit BCD adder. It chains the carry between digits. Subtraction is done by ten's complement, with a second correction pass when the result is negative. It sits above the one-digit BCD add/sub datapath and turns it into an N-digit calculator engine with a start/done handshake.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op_sub  in  1  0 = a+b, 1 = a−b; latched with start
- a  in  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- busy  out  1  high from the cycle after start is accepted through the done cycle inclusive
- done  out  1  one-cycle pulse; result and flags valid from this cycle on
- result  out  4*DIGITS  magnitude of the result, packed BCD
- carry_out  out  1  add overflow (decimal carry out of the MSD); 0 for subtract
- negative  out  1  subtract result < 0; result holds |a−b|
- bcd_err  out  1  an operand digit was >9 (see Configuration)

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE to RUN:
  - Taken when start=1.
  - Latch a, b, op_sub; clear result, carry_out, negative, bcd_err; idx=0.
  - Initial carry = op_sub.
- RUN, digit idx:
  - Adder inputs: x = a[idx], y = op_sub ? 9−b[idx] : b[idx], cin = carry.
  - Write sum digit to result[idx]; carry ← cout; idx++.
- End of RUN, at the last digit (idx = DIGITS−1):
  - Add: carry_out ← final cout; go to DONE.
  - Subtract, final cout=1: negative=0; go to DONE.
  - Subtract, final cout=0: negative←1; idx←0; carry←1; go to FIX.
- FIX, digit idx:
  - Adder inputs: x = 9−result[idx], y = 0, cin = carry.
  - Write back to result[idx]; go to DONE after the last digit.
  - FIX forms the ten's complement of the stored result.
- DONE: done=1 for one cycle, then IDLE.
- Outputs hold their values until the next accepted start.
- Arithmetic:
  - The adder computes s = x+y+cin (0..19).
  - If s > 9: digit = s−10 and cout = 1; otherwise digit = s and cout = 0.
  - All digit math is 5-bit internally; result digits are always 0..9.
- Boundaries:
  - start while busy: ignored, with no effect on the running operation.
  - start held high through DONE: a new operation is accepted in the following IDLE cycle.
  - a == b on subtract: result 0, negative 0.
  - DIGITS=1: RUN lasts one cycle.
- Reset (any time, including mid-operation):
  - State IDLE, idx 0.
  - busy, done, result, carry_out, negative, bcd_err all 0.

## Timing
- start sampled at edge k: busy=1 from k+1.
- Add, or subtract with non-negative result: done asserted in cycle k+DIGITS+1.
- Negative subtract: done in cycle k+2*DIGITS+1.
- Minimum start-to-start spacing: DIGITS+2 cycles.
- The adder is combinational inside a single cycle; no registers sit between the adder and result.

## Configuration
- BCD_SEQ_CHECK_EN defined:
  - Each RUN cycle checks a[idx] and b[idx] for values >9.
  - Any hit sets bcd_err, which is sticky until the next accepted start.
  - Operation completes normally; the result is don't-care when bcd_err=1.
- Macro undefined: bcd_err is tied to 0 and the check logic is absent.

## Structure
- Package bcd_seq_pkg:
  - state enum (IDLE, RUN, FIX, DONE)
  - DIGIT_W=4
  - BCD_NINE=4'd9
  - nines-complement function
- Sub-module bcd_digit_add: combinational one-digit BCD adder (x, y, cin → digit, cout), instantiated once and shared by RUN and FIX.

## Test plan
- DIGITS=4, add 0042+0057 → result 0099, carry_out 0, negative 0; done at k+5.
- add 9999+0001 → result 0000, carry_out 1.
- sub 0057−0042 → result 0015, negative 0, done at k+5.
- sub 0042−0057 → FIX pass, result 0015, negative 1, done at k+9; sub 1234−1234 → 0000, negative 0.
- start pulsed mid-RUN with other operands → ignored, first result unchanged; rst_n low mid-FIX → all outputs 0, IDLE; a fresh start then completes correctly.
- BCD_SEQ_CHECK_EN defined: a=00A1 add → bcd_err 1 at done, cleared by the next start; macro undefined: bcd_err stays 0.
